// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg
//   Constants shared by the operand-fetch stage and the ALU. The ALU opcode
//   encodings live here so that both sides agree on them. This package also
//   holds the default datapath width and the register-index width.
package alu_operand_stage_pkg;

    localparam int ALU_WORD_SIZE     = 18;
    localparam int ALU_REG_COUNT     = 8;
    localparam int ALU_REG_ADDR_BITS = 3;
    localparam int ALU_OP_BITS       = 4;

    localparam logic [ALU_OP_BITS-1:0] ALU_OP_PASS = 4'h0;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_ADD  = 4'h1;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_SUB  = 4'h2;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_AND  = 4'h3;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_OR   = 4'h4;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_XOR  = 4'h5;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_SHL  = 4'h6;
    localparam logic [ALU_OP_BITS-1:0] ALU_OP_SHR  = 4'h7;

endpackage

// File: rtl/alu_operand_stage_regfile_bypass.sv
// alu_operand_stage_regfile_bypass
//   Architectural register file with one write port and two combinational
//   read ports. A read of the register being written this cycle returns the
//   write data (bypass). Register 0 always reads as zero, and writes to it
//   are discarded.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset (clears all regs)
//     wr_en/addr/data     write port (writeback)
//     ra_addr -> ra_data  bypassed read port A
//     rb_addr -> rb_data  bypassed read port B
module alu_operand_stage_regfile_bypass
    import alu_operand_stage_pkg::*;
#(
    parameter int WORD_SIZE     = ALU_WORD_SIZE,
    parameter int REG_COUNT     = ALU_REG_COUNT,
    parameter int REG_ADDR_BITS = ALU_REG_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [REG_ADDR_BITS-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]     wr_data,
    input  logic [REG_ADDR_BITS-1:0] ra_addr,
    output logic [WORD_SIZE-1:0]     ra_data,
    input  logic [REG_ADDR_BITS-1:0] rb_addr,
    output logic [WORD_SIZE-1:0]     rb_data
);

    logic [WORD_SIZE-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // The zero check comes last so it overrides the bypass as well.
    always_comb begin
        ra_data = regs[ra_addr];
        if (wr_en && (wr_addr == ra_addr)) ra_data = wr_data;
        if (ra_addr == '0) ra_data = '0;
    end

    always_comb begin
        rb_data = regs[rb_addr];
        if (wr_en && (wr_addr == rb_addr)) rb_data = wr_data;
        if (rb_addr == '0) rb_data = '0;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand-fetch stage in front of the ALU. It accepts a decoded instruction
//   on a valid/ready handshake and reads ra/rb from the register file, using
//   the writeback bypass. When imm_en is set, the immediate replaces rb. The
//   stage then presents registered operands, the opcode and the destination
//   to the ALU. A per-register pending scoreboard stalls any instruction that
//   would read a register, or overwrite a destination, while an older result
//   for that register is still outstanding.
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid / in_ready        decoded-instruction handshake
//     in_op, in_ra, in_rb,
//     in_imm_en, in_imm,
//     in_rd, in_wr               decoded instruction fields
//     out_valid / out_ready      handshake towards the ALU
//     out_r0, out_r1, out_op,
//     out_rd, out_wr             registered ALU operands and writeback tag
//     wb_en, wb_addr, wb_data    ALU result writeback
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int WORD_SIZE     = ALU_WORD_SIZE,
    parameter int REG_COUNT     = ALU_REG_COUNT,
    parameter int REG_ADDR_BITS = ALU_REG_ADDR_BITS,
    parameter int OP_BITS       = ALU_OP_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_BITS-1:0]       in_op,
    input  logic [REG_ADDR_BITS-1:0] in_ra,
    input  logic [REG_ADDR_BITS-1:0] in_rb,
    input  logic                     in_imm_en,
    input  logic [WORD_SIZE-1:0]     in_imm,
    input  logic [REG_ADDR_BITS-1:0] in_rd,
    input  logic                     in_wr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_SIZE-1:0]     out_r0,
    output logic [WORD_SIZE-1:0]     out_r1,
    output logic [OP_BITS-1:0]       out_op,
    output logic [REG_ADDR_BITS-1:0] out_rd,
    output logic                     out_wr,
    input  logic                     wb_en,
    input  logic [REG_ADDR_BITS-1:0] wb_addr,
    input  logic [WORD_SIZE-1:0]     wb_data
);

    logic [REG_COUNT-1:0]     pending;
    logic [WORD_SIZE-1:0]     src_a;
    logic [WORD_SIZE-1:0]     src_b;
    logic                     blocked;
    logic                     accept;

    logic                     vld_p1;
    logic [WORD_SIZE-1:0]     r0_p1;
    logic [WORD_SIZE-1:0]     r1_p1;
    logic [OP_BITS-1:0]       op_p1;
    logic [REG_ADDR_BITS-1:0] rd_p1;
    logic                     wr_p1;

    // A register is hazardous while its result is outstanding, unless that
    // result is being written back right now (the bypass then supplies it).
    function automatic logic hazard(input logic [REG_ADDR_BITS-1:0] x,
                                    input logic [REG_COUNT-1:0]     pend,
                                    input logic                     wbe,
                                    input logic [REG_ADDR_BITS-1:0] wba);
        return (x != '0) && pend[x] && !(wbe && (wba == x));
    endfunction

    alu_operand_stage_regfile_bypass #(
        .WORD_SIZE     (WORD_SIZE),
        .REG_COUNT     (REG_COUNT),
        .REG_ADDR_BITS (REG_ADDR_BITS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data),
        .ra_addr (in_ra),
        .ra_data (src_a),
        .rb_addr (in_rb),
        .rb_data (src_b)
    );

    // A destination hazard also stalls. This keeps two writers of the same
    // register in order, so that a single pending bit per register is enough.
    assign blocked = hazard(in_ra, pending, wb_en, wb_addr)
                   | (!in_imm_en && hazard(in_rb, pending, wb_en, wb_addr))
                   | (in_wr && hazard(in_rd, pending, wb_en, wb_addr));

    assign in_ready = !blocked && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;

    // Scoreboard: a new claim on a register wins over a same-cycle writeback.
    // Register 0 has no pending bit and stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (accept && in_wr && (in_rd == REG_ADDR_BITS'(i))) begin
                    pending[i] <= 1'b1;
                end else if (wb_en && (wb_addr == REG_ADDR_BITS'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // ---- stage boundary: fetched operands -> ALU (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_p1 <= '0;
            r1_p1 <= '0;
            op_p1 <= '0;
            rd_p1 <= '0;
            wr_p1 <= 1'b0;
        end else if (accept) begin
            r0_p1 <= src_a;
            r1_p1 <= in_imm_en ? in_imm : src_b;
            op_p1 <= in_op;
            rd_p1 <= in_rd;
            wr_p1 <= in_wr;
        end
    end

    assign out_valid = vld_p1;
    assign out_r0    = r0_p1;
    assign out_r1    = r1_p1;
    assign out_op    = op_p1;
    assign out_rd    = rd_p1;
    assign out_wr    = wr_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
//   Directed, table-driven bench for alu_operand_stage. Each table row gives
//   the inputs that are driven for one cycle. It also gives the in_ready value
//   expected during that cycle and the registered outputs expected after the
//   following rising edge. A hand-written sequence covers the asynchronous
//   reset that happens during a stall.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam logic [31:0] PASS_ = 32'(ALU_OP_PASS);
    localparam logic [31:0] ADD   = 32'(ALU_OP_ADD);
    localparam logic [31:0] SUB   = 32'(ALU_OP_SUB);
    localparam logic [31:0] AND_  = 32'(ALU_OP_AND);
    localparam logic [31:0] OR_   = 32'(ALU_OP_OR);
    localparam logic [31:0] XOR_  = 32'(ALU_OP_XOR);
    localparam logic [31:0] SHL   = 32'(ALU_OP_SHL);
    localparam logic [31:0] SHR   = 32'(ALU_OP_SHR);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_ra;
    logic [2:0]  in_rb;
    logic        in_imm_en;
    logic [17:0] in_imm;
    logic [2:0]  in_rd;
    logic        in_wr;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_r0;
    logic [17:0] out_r1;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic        out_wr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [17:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_imm_en (in_imm_en),
        .in_imm    (in_imm),
        .in_rd     (in_rd),
        .in_wr     (in_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r0    (out_r0),
        .out_r1    (out_r1),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .out_wr    (out_wr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    typedef struct {
        logic [31:0] iv, op, ra, rb, ie, imm, rd, wr, ordy, wbe, wba, wbd;
        logic [31:0] erdy, evld, er0, er1, eop, erd, ewr;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] iv, op, ra, rb, ie, imm, rd, wr, ordy, wbe, wba, wbd,
        input logic [31:0] erdy, evld, er0, er1, eop, erd, ewr);
        vec_t v;
        v.iv = iv; v.op = op; v.ra = ra; v.rb = rb; v.ie = ie; v.imm = imm;
        v.rd = rd; v.wr = wr; v.ordy = ordy; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
        v.erdy = erdy; v.evld = evld; v.er0 = er0; v.er1 = er1;
        v.eop = eop; v.erd = erd; v.ewr = ewr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid  = v.iv[0];
        in_op     = v.op[3:0];
        in_ra     = v.ra[2:0];
        in_rb     = v.rb[2:0];
        in_imm_en = v.ie[0];
        in_imm    = v.imm[17:0];
        in_rd     = v.rd[2:0];
        in_wr     = v.wr[0];
        out_ready = v.ordy[0];
        wb_en     = v.wbe[0];
        wb_addr   = v.wba[2:0];
        wb_data   = v.wbd[17:0];
    endtask

    task automatic chk_out(input string tag, input logic [31:0] evld, er0, er1, eop, erd, ewr);
        chk({tag, ".out_valid"}, 32'(out_valid), evld);
        chk({tag, ".out_r0"},    32'(out_r0),    er0);
        chk({tag, ".out_r1"},    32'(out_r1),    er1);
        chk({tag, ".out_op"},    32'(out_op),    eop);
        chk({tag, ".out_rd"},    32'(out_rd),    erd);
        chk({tag, ".out_wr"},    32'(out_wr),    ewr);
    endtask

    vec_t vecs [26];
    vec_t v;

    initial begin
        //                iv op    ra rb ie imm       rd wr ordy wbe wba wbd        | rdy vld r0        r1        op    rd wr
        vecs[0]  = mk(1, ADD,  0, 0, 1, 'h3FFFF, 0, 0, 1, 0, 0, 0,        1, 1, 0,        'h3FFFF, ADD,  0, 0);
        vecs[1]  = mk(0, PASS_,0, 0, 0, 0,       0, 0, 1, 1, 3, 'h12345,  1, 0, 0,        'h3FFFF, ADD,  0, 0);
        vecs[2]  = mk(1, SUB,  3, 3, 0, 0,       1, 0, 1, 0, 0, 0,        1, 1, 'h12345,  'h12345, SUB,  1, 0);
        vecs[3]  = mk(1, XOR_, 5, 0, 0, 0,       0, 0, 1, 1, 5, 'h00ABC,  1, 1, 'h00ABC,  0,       XOR_, 0, 0);
        vecs[4]  = mk(1, ADD,  3, 5, 0, 0,       2, 1, 1, 0, 0, 0,        1, 1, 'h12345,  'h00ABC, ADD,  2, 1);
        vecs[5]  = mk(1, OR_,  2, 0, 1, 1,       6, 1, 1, 0, 0, 0,        0, 0, 'h12345,  'h00ABC, ADD,  2, 1);
        vecs[6]  = mk(1, OR_,  2, 0, 1, 1,       6, 1, 1, 0, 0, 0,        0, 0, 'h12345,  'h00ABC, ADD,  2, 1);
        vecs[7]  = mk(1, OR_,  2, 0, 1, 1,       6, 1, 1, 1, 2, 'h00077,  1, 1, 'h00077,  1,       OR_,  6, 1);
        vecs[8]  = mk(0, PASS_,0, 0, 0, 0,       0, 0, 1, 0, 0, 0,        1, 0, 'h00077,  1,       OR_,  6, 1);
        vecs[9]  = mk(1, AND_, 3, 0, 1, 'h2AAAA, 0, 0, 0, 0, 0, 0,        1, 1, 'h12345,  'h2AAAA, AND_, 0, 0);
        vecs[10] = mk(1, SHL,  5, 3, 0, 0,       0, 0, 0, 0, 0, 0,        0, 1, 'h12345,  'h2AAAA, AND_, 0, 0);
        vecs[11] = mk(1, SHL,  5, 3, 0, 0,       0, 0, 0, 0, 0, 0,        0, 1, 'h12345,  'h2AAAA, AND_, 0, 0);
        vecs[12] = mk(1, SHL,  5, 3, 0, 0,       0, 0, 0, 0, 0, 0,        0, 1, 'h12345,  'h2AAAA, AND_, 0, 0);
        vecs[13] = mk(1, SHL,  5, 3, 0, 0,       0, 0, 1, 0, 0, 0,        1, 1, 'h00ABC,  'h12345, SHL,  0, 0);
        vecs[14] = mk(1, SHR,  2, 0, 1, 'h15555, 0, 0, 1, 0, 0, 0,        1, 1, 'h00077,  'h15555, SHR,  0, 0);
        vecs[15] = mk(0, PASS_,0, 0, 0, 0,       0, 0, 1, 0, 0, 0,        1, 0, 'h00077,  'h15555, SHR,  0, 0);
        vecs[16] = mk(0, PASS_,0, 0, 0, 0,       0, 0, 1, 1, 0, 'h11111,  1, 0, 'h00077,  'h15555, SHR,  0, 0);
        vecs[17] = mk(1, PASS_,0, 0, 0, 0,       0, 1, 1, 1, 0, 'h11111,  1, 1, 0,        0,       PASS_,0, 1);
        vecs[18] = mk(1, ADD,  0, 0, 1, 'h00042, 7, 0, 1, 0, 0, 0,        1, 1, 0,        'h00042, ADD,  7, 0);
        vecs[19] = mk(1, ADD,  1, 1, 0, 0,       6, 1, 1, 0, 0, 0,        0, 0, 0,        'h00042, ADD,  7, 0);
        vecs[20] = mk(1, SUB,  0, 6, 0, 0,       0, 0, 1, 0, 0, 0,        0, 0, 0,        'h00042, ADD,  7, 0);
        vecs[21] = mk(1, SUB,  0, 6, 1, 9,       0, 0, 1, 0, 0, 0,        1, 1, 0,        9,       SUB,  0, 0);
        vecs[22] = mk(1, ADD,  0, 0, 1, 0,       6, 1, 1, 1, 6, 'h3FFFF,  1, 1, 0,        0,       ADD,  6, 1);
        vecs[23] = mk(1, OR_,  6, 0, 1, 1,       0, 0, 1, 0, 0, 0,        0, 0, 0,        0,       ADD,  6, 1);
        vecs[24] = mk(1, OR_,  6, 0, 1, 1,       0, 0, 1, 1, 6, 'h00100,  1, 1, 'h00100,  1,       OR_,  0, 0);
        vecs[25] = mk(1, XOR_, 6, 6, 0, 0,       0, 0, 1, 0, 0, 0,        1, 1, 'h00100,  'h00100, XOR_, 0, 0);

        rst_n = 1'b0;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), vecs[i].erdy);
            @(posedge clk);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].evld, vecs[i].er0, vecs[i].er1,
                    vecs[i].eop, vecs[i].erd, vecs[i].ewr);
        end

        // Claim r4, then stall on a read of r4, then reset asynchronously.
        v = mk(1, ADD, 0, 0, 1, 5, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        #1 chk("rst.claim.in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk_out("rst.claim", 1, 0, 5, ADD, 4, 1);
        v = mk(1, SUB, 4, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        #1 chk("rst.stall.in_ready", 32'(in_ready), 0);
        #1 rst_n = 1'b0;
        #1 chk_out("rst.async", 0, 0, 0, 0, 0, 0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        chk("rst.after.in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk_out("rst.after", 1, 0, 0, SUB, 0, 0);

        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch pipeline stage directly upstream of the ALU.
- Accepts decoded instructions via a valid/ready handshake and reads two sources from an internal register file, substituting an immediate when selected.
- Presents registered r0/r1/op to the ALU and takes the ALU result back through a writeback port.
- Includes a per-register pending scoreboard and a writeback bypass so that read-after-write hazards stall rather than read stale data.

Parameters:
WORD_SIZE, 18, datapath width; matches the ALU.
REG_COUNT, 8, number of architectural registers.
REG_ADDR_BITS, 3, log2(REG_COUNT).
OP_BITS, 4, ALU opcode width.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  decoded instruction present.
in_ready  out  1  stage accepts instruction this cycle.
in_op  in  OP_BITS  ALU operation, passed through unchanged.
in_ra  in  REG_ADDR_BITS  source A register (feeds r0).
in_rb  in  REG_ADDR_BITS  source B register (feeds r1 when in_imm_en=0).
in_imm_en  in  1  1 selects in_imm as r1.
in_imm  in  WORD_SIZE  immediate operand.
in_rd  in  REG_ADDR_BITS  destination register.
in_wr  in  1  instruction writes in_rd.
out_valid  out  1  operands valid to ALU.
out_ready  in  1  ALU/execute consumes this cycle.
out_r0  out  WORD_SIZE  ALU r0 operand.
out_r1  out  WORD_SIZE  ALU r1 operand.
out_op  out  OP_BITS  ALU op.
out_rd  out  REG_ADDR_BITS  destination, carried to writeback.
out_wr  out  1  writeback required.
wb_en  in  1  writeback strobe.
wb_addr  in  REG_ADDR_BITS  writeback register.
wb_data  in  WORD_SIZE  writeback value (ALU res).

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_r0=0, out_r1=0, out_op=0, out_rd=0, out_wr=0.
  - All registers=0; all pending bits=0.
  - Deassertion is synchronised externally; the first active edge after release behaves normally.
  - Reset mid-operation drops the in-flight instruction and all pending bits.
- Register 0 reads as 0 always. Writes to register 0 are ignored and never set a pending bit.
- Read with bypass (combinational):
  - src(a) = 0 if a==0
  - else wb_data if wb_en && wb_addr==a
  - else regs[a].
- Hazard:
  - Instruction is blocked if, for any of ra, rb (rb only when in_imm_en=0), rd (only when in_wr=1 and rd!=0), the register is non-zero, pending[x]=1, and x is not being written back this cycle (wb_en && wb_addr==x clears the hazard).
- in_ready = !blocked && (!out_valid || out_ready). in_ready depends on in_* when in_valid=1; in_valid may not depend on in_ready.
- Accept when in_valid && in_ready. On the next edge:
  - out_valid=1
  - out_r0=src(ra)
  - out_r1 = in_imm_en ? in_imm : src(rb)
  - out_op, out_rd, out_wr copied from inputs.
- If out_valid && out_ready && no accept, then out_valid=0. Payload holds its last value.
- Payload is stable while out_valid && !out_ready. Latency from accept to out_valid is 1 cycle. Throughput is 1 per cycle when there are no hazards.
- Writeback: on wb_en && wb_addr!=0, regs[wb_addr]<=wb_data and pending[wb_addr]<=0.
- Pending set: on accept with in_wr && in_rd!=0, pending[in_rd]<=1. If the same register is also cleared by writeback in the same cycle, set wins.
- wb_en for a non-pending register is legal: the register is written and the pending bit stays 0.
- Arithmetic: none. All widths are exact; no truncation or extension.

Decomposition:
- Shared package: ALU_OP_* opcode constants (shared with the ALU), WORD_SIZE default, register-index width.
- Natural sub-module: regfile_bypass, holding the register array, register-0 zero, the two bypassed read ports and the write port.
- Scoreboard and handshake logic stay in alu_operand_stage.

Test Plan:
1. Reset then idle: outputs all 0, in_ready=1. Accept ra=0, imm_en=1, imm=0x3FFFF, op=ALU_OP_ADD → next cycle out_valid=1, r0=0, r1=0x3FFFF, op=ADD.
2. Writeback wb r3=0x12345, then issue ra=3, rb=3 → r0=r1=0x12345. Same-cycle wb r5=0x00ABC with issue ra=5 → r0=0x00ABC via bypass.
3. RAW stall: issue rd=2, wr=1; next issue ra=2 → in_ready=0 until wb r2=0x00077. Accepted in the wb cycle with r0=0x00077; out_valid follows 1 cycle later.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 → payload unchanged, in_ready=0. Raise out_ready with in_valid held → back-to-back transfer, no lost or duplicated instruction.
5. Register 0: wb r0=0x11111, then read ra=0 → 0. Issue rd=0, wr=1 → no pending bit set; a following ra=0 does not stall.
6. Async reset mid-stall: pending r4 set, rst_n low for half a cycle → out_valid=0 immediately, pending cleared. After release, ra=4 accepted without stall and r0=0.
